// File: rtl/mac_seq_if.sv
// Job, operand and result handshake bundle between a MAC lane sequencer and its neighbours.
// master = job/operand source and result sink, slave = the sequencer.
interface mac_seq_if #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int LEN_WIDTH      = 8
);
  logic                      start;
  logic [MAC_CONF_WIDTH-1:0] cfg_in;
  logic [LEN_WIDTH-1:0]      len_in;
  logic                      op_valid;
  logic                      op_ready;
  logic                      dp_en;
  logic [MAC_CONF_WIDTH-1:0] dp_cfg;
  logic                      acc_load;
  logic                      res_valid;
  logic                      res_ready;
  logic                      busy;
  logic                      err_len;

  modport master (
    output start, cfg_in, len_in, op_valid, res_ready,
    input  op_ready, dp_en, dp_cfg, acc_load, res_valid, busy, err_len
  );

  modport slave (
    input  start, cfg_in, len_in, op_valid, res_ready,
    output op_ready, dp_en, dp_cfg, acc_load, res_valid, busy, err_len
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC lane sequencer: job of N operands, then PIPE_LAT drain cycles; result held until res_ready.
// op_ready/dp_en/acc_load are combinational; MAC_SEQ_PERF_EN adds perf_stall/perf_jobs counters.
module mac_seq_ctrl #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int PIPE_LAT       = 3
) (
  input  logic        clk,
  input  logic        rst,
  mac_seq_if.slave    bus
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [15:0] perf_stall,
  output logic [15:0] perf_jobs
`endif
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [LEN_WIDTH-1:0]      rem_q, rem_d;
  logic [DW-1:0]             drn_q, drn_d;
  logic                      first_q, first_d;
  logic [MAC_CONF_WIDTH-1:0] cfg_q, cfg_d;
  logic                      res_vld_q, res_vld_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;

  logic in_run;
  logic in_drain;
  logic accept;

  assign in_run   = (state_q == S_RUN);
  assign in_drain = (state_q == S_DRAIN);
  assign accept   = in_run & bus.op_valid;

  assign bus.op_ready  = in_run;
  assign bus.dp_en     = accept | in_drain;
  assign bus.acc_load  = accept & first_q;
  assign bus.dp_cfg    = cfg_q;
  assign bus.res_valid = res_vld_q;
  assign bus.busy      = busy_q;
  assign bus.err_len   = err_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    drn_d     = drn_q;
    first_d   = first_q;
    cfg_d     = cfg_q;
    res_vld_d = res_vld_q;
    busy_d    = busy_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len_in != '0) begin
            // mul-only jobs take exactly one operand regardless of the requested length
            cfg_d   = bus.cfg_in;
            rem_d   = bus.cfg_in[2] ? LEN_WIDTH'(1) : bus.len_in;
            first_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (accept) begin
          first_d = 1'b0;
          rem_d   = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            drn_d   = DW'(PIPE_LAT);
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        drn_d = drn_q - DW'(1);
        if (drn_q == DW'(1)) begin
          res_vld_d = 1'b1;
          state_d   = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.res_ready) begin
          res_vld_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        res_vld_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      drn_q     <= '0;
      first_q   <= 1'b0;
      cfg_q     <= '0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      drn_q     <= drn_d;
      first_q   <= first_d;
      cfg_q     <= cfg_d;
      res_vld_q <= res_vld_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] jobs_q, jobs_d;
  logic        stall_inc;
  logic        job_inc;

  assign stall_inc = (in_run & ~bus.op_valid) | ((state_q == S_HOLD) & ~bus.res_ready);
  assign job_inc   = (state_q == S_HOLD) & bus.res_ready;

  // both counters stick at all-ones rather than wrapping
  assign stall_d = (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  assign jobs_d  = (job_inc && jobs_q != 16'hFFFF) ? jobs_q + 16'd1 : jobs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      jobs_q  <= '0;
    end else begin
      stall_q <= stall_d;
      jobs_q  <= jobs_d;
    end
  end

  assign perf_stall = stall_q;
  assign perf_jobs  = jobs_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: vector table, hand sequences and random jobs scored on per-job
// aggregates (accept count, load position, dp_en total, result timing, cfg stability).
module tb_mac_seq_ctrl;
  localparam int CW = 4;
  localparam int LW = 8;
  localparam int PL = 3;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_if #(.MAC_CONF_WIDTH(CW), .LEN_WIDTH(LW)) bus ();

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_jobs;
`endif

  mac_seq_ctrl #(.MAC_CONF_WIDTH(CW), .LEN_WIDTH(LW), .PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MAC_SEQ_PERF_EN
    ,
    .perf_stall (perf_stall),
    .perf_jobs  (perf_jobs)
`endif
  );

  typedef struct {
    logic [3:0] cfg;
    logic [7:0] len;
    int         exp_acc;
    int         exp_rise;
    int         exp_err;
  } vec_t;

  typedef struct {
    int acc;
    int first_acc;
    int last_acc;
    int loads;
    int load_cyc;
    int dpen;
    int bad_dpen;
    int rise;
    int hold;
    int drop;
    int cfg_bad;
    int errs;
    int busy_bad;
    int busy_after;
    int timeout;
  } res_t;

  int errors = 0;
  int checks = 0;
  logic [3:0] last_cfg;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", nm, what, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.cfg_in    = '0;
    bus.len_in    = '0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_cfg = '0;
  endtask

  // One job from IDLE. vpct<0 selects op_valid from vpat bits; hold_low>=0 keeps res_ready
  // low for that many result cycles, otherwise res_ready is random with rpct percent.
  task automatic run_job(input logic [3:0] cfg, input logic [7:0] len, input int vpct,
                         input logic [31:0] vpat, input int rpct, input int hold_low,
                         input bit noise, output res_t r);
    logic [3:0] cfg_exp;
    bit done;
    r = '{default: 0};
    r.first_acc = -1; r.last_acc = -1; r.load_cyc = -1; r.rise = -1;
    cfg_exp = (len != 0) ? cfg : last_cfg;
    bus.start = 1'b1; bus.cfg_in = cfg; bus.len_in = len;
    bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    @(posedge clk); #1;
    done = 1'b0;
    for (int c = 1; c <= LIMIT && !done; c++) begin
      bus.start = 1'b0;
      if (noise && len != 0) begin
        bus.cfg_in = ~bus.cfg_in;
        bus.len_in = LW'($urandom);
        bus.start  = bus.res_valid | 1'($urandom);
      end
      if (vpct < 0) bus.op_valid = (c <= 32) ? vpat[c-1] : 1'b1;
      else          bus.op_valid = ($urandom_range(99) < vpct);
      if (hold_low >= 0) bus.res_ready = bus.res_valid && (r.hold >= hold_low);
      else               bus.res_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (bus.op_ready && bus.op_valid) begin
        r.acc++;
        if (r.first_acc < 0) r.first_acc = c;
        r.last_acc = c;
      end
      if (bus.acc_load) begin
        r.loads++;
        if (r.load_cyc < 0) r.load_cyc = c;
      end
      if (bus.dp_en) begin
        r.dpen++;
        if ((bus.op_ready && !bus.op_valid) || bus.res_valid) r.bad_dpen++;
      end
      if (bus.res_valid) begin
        if (r.rise < 0) r.rise = c;
        r.hold++;
      end else if (r.rise >= 0) r.drop++;
      if (bus.dp_cfg !== cfg_exp) r.cfg_bad++;
      if (bus.err_len) r.errs++;
      if (bus.busy !== ((len != 0) ? 1'b1 : 1'b0)) r.busy_bad++;
      if (len == 0) begin
        if (c == 2) done = 1'b1;
      end else if (bus.res_valid && bus.res_ready) done = 1'b1;
      if (!done && c == LIMIT) r.timeout = 1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    @(negedge clk);
    r.busy_after = bus.busy;
    @(posedge clk); #1;
    if (r.timeout != 0) do_reset();
    else if (len != 0) last_cfg = cfg;
  endtask

  task automatic check_job(input string nm, input logic [3:0] cfg, input logic [7:0] len, input res_t r);
    int neff;
    neff = (len == 0) ? 0 : (cfg[2] ? 1 : int'(len));
    chk(nm, "timeout", r.timeout, 0);
    chk(nm, "accepts", r.acc, neff);
    chk(nm, "cfg_stable", r.cfg_bad, 0);
    chk(nm, "busy", r.busy_bad, 0);
    chk(nm, "busy_after", r.busy_after, 0);
    if (len == 0) begin
      chk(nm, "err_len", r.errs, 1);
      chk(nm, "dp_en", r.dpen, 0);
    end else begin
      chk(nm, "err_len", r.errs, 0);
      chk(nm, "loads", r.loads, 1);
      chk(nm, "load_first", r.load_cyc, r.first_acc);
      chk(nm, "dp_en", r.dpen, neff + PL);
      chk(nm, "dp_en_stray", r.bad_dpen, 0);
      chk(nm, "res_rise", r.rise, r.last_acc + PL + 1);
      chk(nm, "res_drop", r.drop, 0);
    end
  endtask

  vec_t tbl[6];
  res_t r;

  initial begin
    logic [3:0] rc;
    logic [7:0] rl;

    tbl[0] = '{cfg: 4'b1010, len: 8'd4,   exp_acc: 4,   exp_rise: 8,   exp_err: 0};
    tbl[1] = '{cfg: 4'b0100, len: 8'd9,   exp_acc: 1,   exp_rise: 5,   exp_err: 0};
    tbl[2] = '{cfg: 4'b0000, len: 8'd1,   exp_acc: 1,   exp_rise: 5,   exp_err: 0};
    tbl[3] = '{cfg: 4'b1111, len: 8'd2,   exp_acc: 1,   exp_rise: 5,   exp_err: 0};
    tbl[4] = '{cfg: 4'b0011, len: 8'd0,   exp_acc: 0,   exp_rise: -1,  exp_err: 1};
    tbl[5] = '{cfg: 4'b0001, len: 8'd255, exp_acc: 255, exp_rise: 259, exp_err: 0};

    rst = 1'b1;
    idle_inputs();
    last_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", "busy", bus.busy, 0);
    chk("reset", "op_ready", bus.op_ready, 0);
    chk("reset", "dp_en", bus.dp_en, 0);
    chk("reset", "acc_load", bus.acc_load, 0);
    chk("reset", "res_valid", bus.res_valid, 0);
    chk("reset", "err_len", bus.err_len, 0);
    chk("reset", "dp_cfg", bus.dp_cfg, 0);
    @(posedge clk); #1 rst = 1'b0;

    // gaps in op_valid and five cycles of result backpressure, cfg_in toggling throughout
    run_job(4'b1001, 8'd3, -1, 32'b11001, 0, 5, 1'b1, r);
    check_job("gaps", 4'b1001, 8'd3, r);
    chk("gaps", "dp_en_total", r.dpen, 6);
    chk("gaps", "res_hold", r.hold, 6);
`ifdef MAC_SEQ_PERF_EN
    chk("perf", "stall", perf_stall, 7);
    chk("perf", "jobs", perf_jobs, 1);
`endif

    // reset mid-RUN after 2 of 5 accepts
    bus.start = 1'b1; bus.cfg_in = 4'b1010; bus.len_in = 8'd5;
    bus.op_valid = 1'b1; bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    chk("midrst", "op_ready1", bus.op_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst", "op_ready2", bus.op_ready, 1);
    chk("midrst", "dp_cfg_before", bus.dp_cfg, 4'b1010);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst", "busy", bus.busy, 0);
    chk("midrst", "op_ready", bus.op_ready, 0);
    chk("midrst", "res_valid", bus.res_valid, 0);
    chk("midrst", "dp_cfg", bus.dp_cfg, 0);
    @(posedge clk); #1 rst = 1'b0;
    last_cfg = '0;
    idle_inputs();
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].cfg, tbl[i].len, 100, '0, 100, -1, 1'b1, r);
      check_job($sformatf("vec%0d", i), tbl[i].cfg, tbl[i].len, r);
      chk($sformatf("vec%0d", i), "tbl_accepts", r.acc, tbl[i].exp_acc);
      chk($sformatf("vec%0d", i), "tbl_rise", r.rise, tbl[i].exp_rise);
      chk($sformatf("vec%0d", i), "tbl_err", r.errs, tbl[i].exp_err);
    end

    for (int i = 0; i < 25; i++) begin
      rc = 4'($urandom);
      rl = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      run_job(rc, rl, int'($urandom_range(30, 100)), '0, int'($urandom_range(30, 100)), -1, 1'b1, r);
      check_job($sformatf("rnd%0d", i), rc, rl, r);
    end

`ifdef MAC_SEQ_PERF_EN
    do_reset();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_in = 4'b0000; bus.len_in = 8'd1;
    bus.op_valid = 1'b1; bus.res_ready = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (70010) @(posedge clk);
    @(negedge clk);
    chk("perf_sat", "res_valid", bus.res_valid, 1);
    chk("perf_sat", "stall", perf_stall, 16'hFFFF);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.res_ready = 1'b0;
    @(negedge clk);
    chk("perf_sat", "jobs", perf_jobs, 1);
    chk("perf_sat", "stall_held", perf_stall, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
